// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory bus signals of load_store_unit.
// master is the unit itself; slave is the core/bus side that drives it.
interface load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              op_store;
    logic [1:0]        op_size;
    logic              op_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [XLEN-1:0]   rdata;
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [NB-1:0]     mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        input  req_valid, op_store, op_size, op_unsigned, addr, wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_err, rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, op_store, op_size, op_unsigned, addr, wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_err, rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: lane alignment, byte enables, load
// extension, and two-beat splitting of accesses that cross a bus word.
module load_store_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rstN,
    load_store_unit_if.master bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [2*NB-1:0] SPAN_ONE = {{(2*NB-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;
    state_t state, state_nxt;

    logic              op_store_q, op_unsigned_q, split_q, resp_err_q;
    logic [1:0]        op_size_q;
    logic [OFF_W-1:0]  off_q;
    logic [NB-1:0]     be2_q, mem_be_q;
    logic [XLEN-1:0]   beat1_q, rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;

    // Request decode, valid while IDLE.
    logic [OFF_W-1:0]  off;
    logic [3:0]        n_bytes;
    logic [2*NB-1:0]   be_span;
    logic [2*XLEN-1:0] wdata_rot;
    logic              split, err;

    always_comb begin
        off       = bus.addr[OFF_W-1:0];
        n_bytes   = 4'd1 << bus.op_size;
        be_span   = ((SPAN_ONE << n_bytes) - SPAN_ONE) << off;
        wdata_rot = {bus.wdata, bus.wdata} << {off, 3'b000};
        split     = (int'(off) + int'(n_bytes)) > NB;
        err       = (XLEN == 32 && bus.op_size == 2'd3) ||
                    (!MISALIGN_EN && (off & OFF_W'(n_bytes - 4'd1)) != '0);
    end

    // Load result: upper beat is zero unless the access was split.
    logic [2*XLEN-1:0] pair, pair_sh;
    logic [XLEN-1:0]   keep, load_val;
    logic              sbit;

    always_comb begin
        pair    = (state == WAIT2) ? {bus.mem_rdata, beat1_q} : {{XLEN{1'b0}}, bus.mem_rdata};
        pair_sh = pair >> {off_q, 3'b000};
        keep    = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (1 << op_size_q)) keep[8*i +: 8] = 8'hFF;
        end
        unique case (op_size_q)
            2'd0:    sbit = pair_sh[7];
            2'd1:    sbit = pair_sh[15];
            2'd2:    sbit = pair_sh[31];
            default: sbit = pair_sh[XLEN-1];
        endcase
        load_val = (pair_sh[XLEN-1:0] & keep) | ({XLEN{sbit & ~op_unsigned_q}} & ~keep);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.req_valid)  state_nxt = err ? RESP : REQ1;
            REQ1:    if (bus.mem_gnt)    state_nxt = WAIT1;
            WAIT1:   if (bus.mem_rvalid) state_nxt = split_q ? REQ2 : RESP;
            REQ2:    if (bus.mem_gnt)    state_nxt = WAIT2;
            WAIT2:   if (bus.mem_rvalid) state_nxt = RESP;
            RESP:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            op_store_q    <= 1'b0;
            op_unsigned_q <= 1'b0;
            op_size_q     <= 2'd0;
            off_q         <= '0;
            split_q       <= 1'b0;
            be2_q         <= '0;
            beat1_q       <= '0;
            rdata_q       <= '0;
            resp_err_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.req_valid) begin
                    op_store_q    <= bus.op_store;
                    op_unsigned_q <= bus.op_unsigned;
                    op_size_q     <= bus.op_size;
                    off_q         <= off;
                    split_q       <= split;
                    be2_q         <= be_span[2*NB-1:NB];
                    resp_err_q    <= err;
                    rdata_q       <= '0;
                    if (!err) begin
                        mem_addr_q  <= {bus.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_be_q    <= be_span[NB-1:0];
                        mem_we_q    <= bus.op_store;
                        mem_wdata_q <= wdata_rot[2*XLEN-1:XLEN];
                    end
                end
                WAIT1: if (bus.mem_rvalid) begin
                    beat1_q <= bus.mem_rdata;
                    if (split_q) begin
                        mem_addr_q <= mem_addr_q + ADDR_W'(NB);
                        mem_be_q   <= be2_q;
                    end else begin
                        rdata_q <= op_store_q ? '0 : load_val;
                    end
                end
                WAIT2: if (bus.mem_rvalid) rdata_q <= op_store_q ? '0 : load_val;
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_req    = (state == REQ1) || (state == REQ2);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = resp_err_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: three instances (32-bit split, 32-bit
// strict alignment, 64-bit split) driven from one vector table plus reset sequences.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    int          sel;
    logic        req_valid, op_store, op_unsigned, mem_gnt, mem_rvalid;
    logic [1:0]  op_size;
    logic [31:0] addr;
    logic [63:0] wdata, mem_rdata;

    load_store_unit_if #(.XLEN(32), .ADDR_W(32)) if0 ();
    load_store_unit_if #(.XLEN(32), .ADDR_W(32)) if1 ();
    load_store_unit_if #(.XLEN(64), .ADDR_W(32)) if2 ();

    assign if0.req_valid   = req_valid && (sel == 0);
    assign if0.op_store    = op_store;
    assign if0.op_size     = op_size;
    assign if0.op_unsigned = op_unsigned;
    assign if0.addr        = addr;
    assign if0.wdata       = wdata[31:0];
    assign if0.mem_gnt     = mem_gnt && (sel == 0);
    assign if0.mem_rvalid  = mem_rvalid && (sel == 0);
    assign if0.mem_rdata   = mem_rdata[31:0];

    assign if1.req_valid   = req_valid && (sel == 1);
    assign if1.op_store    = op_store;
    assign if1.op_size     = op_size;
    assign if1.op_unsigned = op_unsigned;
    assign if1.addr        = addr;
    assign if1.wdata       = wdata[31:0];
    assign if1.mem_gnt     = mem_gnt && (sel == 1);
    assign if1.mem_rvalid  = mem_rvalid && (sel == 1);
    assign if1.mem_rdata   = mem_rdata[31:0];

    assign if2.req_valid   = req_valid && (sel == 2);
    assign if2.op_store    = op_store;
    assign if2.op_size     = op_size;
    assign if2.op_unsigned = op_unsigned;
    assign if2.addr        = addr;
    assign if2.wdata       = wdata;
    assign if2.mem_gnt     = mem_gnt && (sel == 2);
    assign if2.mem_rvalid  = mem_rvalid && (sel == 2);
    assign if2.mem_rdata   = mem_rdata;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut0 (.clk(clk), .rstN(rstN), .bus(if0.master));
    load_store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut1 (.clk(clk), .rstN(rstN), .bus(if1.master));
    load_store_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut2 (.clk(clk), .rstN(rstN), .bus(if2.master));

    // Outputs of the selected instance, zero-extended to 64 bits.
    logic        o_ready, o_resp_valid, o_resp_err, o_mem_req, o_mem_we;
    logic [7:0]  o_mem_be;
    logic [31:0] o_mem_addr;
    logic [63:0] o_rdata, o_mem_wdata;

    always_comb begin
        o_ready = 1'b0; o_resp_valid = 1'b0; o_resp_err = 1'b0; o_mem_req = 1'b0; o_mem_we = 1'b0;
        o_mem_be = '0; o_mem_addr = '0; o_rdata = '0; o_mem_wdata = '0;
        case (sel)
            0: begin
                o_ready = if0.req_ready; o_resp_valid = if0.resp_valid; o_resp_err = if0.resp_err;
                o_mem_req = if0.mem_req; o_mem_we = if0.mem_we; o_mem_be = {4'b0, if0.mem_be};
                o_mem_addr = if0.mem_addr; o_rdata = {32'b0, if0.rdata}; o_mem_wdata = {32'b0, if0.mem_wdata};
            end
            1: begin
                o_ready = if1.req_ready; o_resp_valid = if1.resp_valid; o_resp_err = if1.resp_err;
                o_mem_req = if1.mem_req; o_mem_we = if1.mem_we; o_mem_be = {4'b0, if1.mem_be};
                o_mem_addr = if1.mem_addr; o_rdata = {32'b0, if1.rdata}; o_mem_wdata = {32'b0, if1.mem_wdata};
            end
            default: begin
                o_ready = if2.req_ready; o_resp_valid = if2.resp_valid; o_resp_err = if2.resp_err;
                o_mem_req = if2.mem_req; o_mem_we = if2.mem_we; o_mem_be = if2.mem_be;
                o_mem_addr = if2.mem_addr; o_rdata = if2.rdata; o_mem_wdata = if2.mem_wdata;
            end
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          sel;
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rd1;
        logic [63:0] rd2;
        int          stall;
        logic        err;
        logic        split;
        logic [7:0]  be1;
        logic [7:0]  be2;
        logic [31:0] addr1;
        logic [31:0] addr2;
        logic [63:0] wd;
        logic [63:0] rdata;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int s, input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [63:0] wd_in, input logic [63:0] r1,
                       input logic [63:0] r2, input int stl, input logic e, input logic sp,
                       input logic [7:0] b1, input logic [7:0] b2, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [63:0] wd_exp, input logic [63:0] rd_exp);
        vec_t v;
        v.sel = s; v.store = st; v.size = sz; v.uns = un; v.addr = a; v.wdata = wd_in;
        v.rd1 = r1; v.rd2 = r2; v.stall = stl; v.err = e; v.split = sp; v.be1 = b1; v.be2 = b2;
        v.addr1 = a1; v.addr2 = a2; v.wd = wd_exp; v.rdata = rd_exp;
        vq.push_back(v);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          beat, stall_left, req_cycles, lat, exp_beats, exp_lat;
        logic        pending, done, err_seen;
        logic [63:0] rdata_seen;
        logic [7:0]  be_seen [2];
        logic [31:0] addr_seen [2];
        logic [63:0] wd_seen [2];
        logic        we_seen [2];
        sel = v.sel;
        @(negedge clk);
        check($sformatf("v%0d.ready", idx), 64'(o_ready), 64'd1);
        req_valid = 1'b1; op_store = v.store; op_size = v.size; op_unsigned = v.uns;
        addr = v.addr; wdata = v.wdata;
        beat = 0; stall_left = v.stall; pending = 1'b0; done = 1'b0; lat = 0; req_cycles = 0;
        err_seen = 1'b0; rdata_seen = '0;
        for (int i = 0; i < 2; i++) begin
            be_seen[i] = '0; addr_seen[i] = '0; wd_seen[i] = '0; we_seen[i] = 1'b0;
        end
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (o_resp_valid) begin
                lat = c; done = 1'b1; err_seen = o_resp_err; rdata_seen = o_rdata;
            end else if (pending) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (beat == 1) ? v.rd1 : v.rd2;
                pending    = 1'b0;
            end else if (o_mem_req) begin
                req_cycles++;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    if (beat < 2) begin
                        be_seen[beat] = o_mem_be; addr_seen[beat] = o_mem_addr;
                        wd_seen[beat] = o_mem_wdata; we_seen[beat] = o_mem_we;
                    end
                    beat++; mem_gnt = 1'b1; pending = 1'b1; stall_left = v.stall;
                end
            end
        end
        exp_beats = v.err ? 0 : (v.split ? 2 : 1);
        exp_lat   = v.err ? 1 : (v.split ? 5 : 3) + exp_beats * v.stall;
        check($sformatf("v%0d.resp_seen", idx), 64'(done), 64'd1);
        check($sformatf("v%0d.latency", idx), 64'(lat), 64'(exp_lat));
        check($sformatf("v%0d.resp_err", idx), 64'(err_seen), 64'(v.err));
        check($sformatf("v%0d.rdata", idx), rdata_seen, v.rdata);
        check($sformatf("v%0d.beats", idx), 64'(beat), 64'(exp_beats));
        check($sformatf("v%0d.req_cycles", idx), 64'(req_cycles), 64'(exp_beats * (v.stall + 1)));
        if (!v.err) begin
            check($sformatf("v%0d.be1", idx), 64'(be_seen[0]), 64'(v.be1));
            check($sformatf("v%0d.addr1", idx), 64'(addr_seen[0]), 64'(v.addr1));
            check($sformatf("v%0d.wdata1", idx), wd_seen[0], v.wd);
            check($sformatf("v%0d.we1", idx), 64'(we_seen[0]), 64'(v.store));
        end
        if (v.split) begin
            check($sformatf("v%0d.be2", idx), 64'(be_seen[1]), 64'(v.be2));
            check($sformatf("v%0d.addr2", idx), 64'(addr_seen[1]), 64'(v.addr2));
            check($sformatf("v%0d.wdata2", idx), wd_seen[1], v.wd);
        end
        @(negedge clk);
        check($sformatf("v%0d.pulse_ends", idx), 64'(o_resp_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_seen;
        rstN = 1'b0; sel = 0; req_valid = 1'b0; op_store = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        //  sel st sz un addr          wdata                  rd1                    rd2                    stl err sp be1    be2    addr1          addr2          wd                     rdata
        add(0, 0, 2, 0, 32'h100,      64'h0,                 64'hDEADBEEF,          64'h0,                 0, 0, 0, 8'h0F, 8'h00, 32'h100,      32'h0,         64'h0,                 64'hDEADBEEF);
        add(0, 0, 0, 0, 32'h103,      64'h0,                 64'h80112233,          64'h0,                 0, 0, 0, 8'h08, 8'h00, 32'h100,      32'h0,         64'h0,                 64'hFFFFFF80);
        add(0, 0, 0, 1, 32'h103,      64'h0,                 64'h80112233,          64'h0,                 0, 0, 0, 8'h08, 8'h00, 32'h100,      32'h0,         64'h0,                 64'h80);
        add(0, 1, 2, 0, 32'h102,      64'hAABBCCDD,          64'h12345678,          64'h9ABCDEF0,          0, 0, 1, 8'h0C, 8'h03, 32'h100,      32'h104,       64'hCCDDAABB,          64'h0);
        add(0, 0, 1, 0, 32'h1FF,      64'h0,                 64'h34000000,          64'h00000012,          2, 0, 1, 8'h08, 8'h01, 32'h1FC,      32'h200,       64'h0,                 64'h1234);
        add(1, 0, 2, 0, 32'h101,      64'h0,                 64'h11111111,          64'h0,                 0, 1, 0, 8'h00, 8'h00, 32'h0,        32'h0,         64'h0,                 64'h0);
        add(0, 0, 3, 0, 32'h100,      64'h0,                 64'h11111111,          64'h0,                 0, 1, 0, 8'h00, 8'h00, 32'h0,        32'h0,         64'h0,                 64'h0);
        add(2, 1, 3, 0, 32'h08,       64'h1122334455667788,  64'h0,                 64'h0,                 0, 0, 0, 8'hFF, 8'h00, 32'h08,       32'h0,         64'h1122334455667788,  64'h0);
        add(2, 0, 2, 0, 32'h0C,       64'h0,                 64'h8000000100000000,  64'h0,                 0, 0, 0, 8'hF0, 8'h00, 32'h08,       32'h0,         64'h0,                 64'hFFFFFFFF80000001);
        add(2, 0, 2, 1, 32'h0C,       64'h0,                 64'h8000000100000000,  64'h0,                 0, 0, 0, 8'hF0, 8'h00, 32'h08,       32'h0,         64'h0,                 64'h80000001);
        add(2, 0, 3, 0, 32'h0B,       64'h0,                 64'h0405060708AAAAAA,  64'hBBBBBBBBBB010203,  0, 0, 1, 8'hF8, 8'h07, 32'h08,       32'h10,        64'h0,                 64'h0102030405060708);
        add(2, 1, 0, 0, 32'h0F,       64'hAB,                64'h0,                 64'h0,                 0, 0, 0, 8'h80, 8'h00, 32'h08,       32'h0,         64'hAB00000000000000,  64'h0);
        add(0, 0, 1, 0, 32'h102,      64'h0,                 64'h80015555,          64'h0,                 0, 0, 0, 8'h0C, 8'h00, 32'h100,      32'h0,         64'h0,                 64'hFFFF8001);
        add(0, 1, 0, 0, 32'h101,      64'hA5,                64'h0,                 64'h0,                 0, 0, 0, 8'h02, 8'h00, 32'h100,      32'h0,         64'h0000A500,          64'h0);
        add(0, 0, 2, 0, 32'hFFFFFFFE, 64'h0,                 64'h22110000,          64'h00004433,          0, 0, 1, 8'h0C, 8'h03, 32'hFFFFFFFC, 32'h0,         64'h0,                 64'h44332211);
        add(1, 0, 1, 0, 32'h102,      64'h0,                 64'h7FFF0000,          64'h0,                 0, 0, 0, 8'h0C, 8'h00, 32'h100,      32'h0,         64'h0,                 64'h7FFF);
        add(2, 0, 0, 1, 32'h12,       64'h0,                 64'h0000000000C30000,  64'h0,                 3, 0, 0, 8'h04, 8'h00, 32'h10,       32'h0,         64'h0,                 64'hC3);

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check($sformatf("rst%0d.ready", s), 64'(o_ready), 64'd1);
            check($sformatf("rst%0d.resp_valid", s), 64'(o_resp_valid), 64'd0);
            check($sformatf("rst%0d.resp_err", s), 64'(o_resp_err), 64'd0);
            check($sformatf("rst%0d.rdata", s), o_rdata, 64'd0);
            check($sformatf("rst%0d.mem_req", s), 64'(o_mem_req), 64'd0);
            check($sformatf("rst%0d.mem_we", s), 64'(o_mem_we), 64'd0);
            check($sformatf("rst%0d.mem_be", s), 64'(o_mem_be), 64'd0);
            check($sformatf("rst%0d.mem_addr", s), 64'(o_mem_addr), 64'd0);
            check($sformatf("rst%0d.mem_wdata", s), o_mem_wdata, 64'd0);
        end
        @(negedge clk);
        rstN = 1'b1;

        foreach (vq[i]) run_vec(i, vq[i]);

        // Reset while the request is on the bus: mem_req must drop without a clock edge.
        sel = 0;
        @(negedge clk);
        req_valid = 1'b1; op_store = 1'b0; op_size = 2'd2; op_unsigned = 1'b0; addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        check("rq1.mem_req_before", 64'(o_mem_req), 64'd1);
        rstN = 1'b0; #1;
        check("rq1.mem_req_async", 64'(o_mem_req), 64'd0);
        check("rq1.ready_async", 64'(o_ready), 64'd1);
        @(negedge clk);
        rstN = 1'b1;

        // 64-bit double store, reset in WAIT1, then a stale read completion.
        sel = 2;
        @(negedge clk);
        req_valid = 1'b1; op_store = 1'b1; op_size = 2'd3; addr = 32'h08; wdata = 64'hCAFEF00D12345678;
        @(negedge clk);
        req_valid = 1'b0;
        check("w1.mem_req", 64'(o_mem_req), 64'd1);
        check("w1.mem_be", 64'(o_mem_be), 64'hFF);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("w1.in_wait_ready", 64'(o_ready), 64'd0);
        rstN = 1'b0; #1;
        check("w1.ready_async", 64'(o_ready), 64'd1);
        check("w1.mem_req_async", 64'(o_mem_req), 64'd0);
        check("w1.mem_be_cleared", 64'(o_mem_be), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'h5555555555555555;
        rv_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (o_resp_valid) rv_seen++;
        end
        check("w1.stale_rvalid_resp", 64'(rv_seen), 64'd0);
        check("w1.ready_after", 64'(o_ready), 64'd1);

        run_vec(100, vq[0]);
        run_vec(101, vq[4]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
